// File: rtl/decoder_nx2n_seq_pkg.sv
// Shared types and helpers for the sequenced N-to-2^N one-hot decoder.
// Select widths up to MAX_SEL_W are supported by the one-hot helper.
package decoder_pkg;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_ONESHOT   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN,
        PULSE
    } state_t;

    // Callers narrow the result to their own output width with a size cast.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT_W-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    function automatic state_t state_for_mode(input mode_t m);
        state_t s;
        unique case (m)
            MODE_DIRECT:    s = DIRECT;
            MODE_SCAN_UP:   s = SCAN;
            MODE_SCAN_DOWN: s = SCAN;
            MODE_ONESHOT:   s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/decoder_nx2n_seq_dwell_timer.sv
// Loadable down-counter shared by the scan dwell and the one-shot strobe.
// Load has priority over decrement; the count saturates at zero.
module dwell_timer
    import decoder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot decoder with direct decode, up/down auto-scan
// and a timed one-shot strobe. y is always zero or onehot(idx).
module decoder_nx2n_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  start,
    output logic [(2**SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  busy,
    output logic                  wrap
);

    localparam int OUT_W = 2 ** SEL_W;

    mode_t              mode_in;
    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic               y_on;

    logic               tmr_load;
    logic               tmr_dec;
    logic [DWELL_W-1:0] tmr_value;
    logic               tmr_zero;
    logic               pulse_done;

    assign mode_in    = mode_t'(mode);
    assign pulse_done = (tmr_value == '0);

    dwell_timer #(
        .WIDTH (DWELL_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (dwell),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // Next-state logic: decides the next index and whether y lights it.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        y_on     = 1'b0;
        busy_d   = 1'b0;
        wrap_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        if (state_q == PULSE) begin
            if (en && (mode_in == MODE_ONESHOT)) begin
                if (pulse_done) begin
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                    y_on    = 1'b1;
                    busy_d  = 1'b1;
                end
            end else begin
                state_d = state_for_mode(mode_in);
            end
        end else begin
            state_d = state_for_mode(mode_in);
            unique case (mode_in)
                MODE_DIRECT: begin
                    if (en) begin
                        idx_d = sel;
                        y_on  = 1'b1;
                    end
                end
                MODE_SCAN_UP, MODE_SCAN_DOWN: begin
                    if (state_q != SCAN) begin
                        tmr_load = 1'b1;
                        y_on     = en;
                    end else if (en) begin
                        y_on = 1'b1;
                        if (tmr_zero) begin
                            // Direction is read at the step, so an UP/DOWN swap needs no reload.
                            tmr_load = 1'b1;
                            if (mode_in == MODE_SCAN_UP) begin
                                idx_d  = idx_q + SEL_W'(1);
                                wrap_d = (idx_q == '1);
                            end else begin
                                idx_d  = idx_q - SEL_W'(1);
                                wrap_d = (idx_q == '0);
                            end
                        end else begin
                            tmr_dec = 1'b1;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if ((state_q == IDLE) && en && start) begin
                        state_d  = PULSE;
                        idx_d    = sel;
                        y_on     = 1'b1;
                        busy_d   = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            endcase
        end
    end

    // y is derived only from the next index, which rules out multi-hot output.
    always_comb begin
        y_d = '0;
        if (y_on) begin
            y_d = OUT_W'(onehot(MAX_SEL_W'(idx_d)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign wrap = wrap_q;

endmodule

// File: doc/decoder_nx2n_seq.md
Name: decoder_nx2n_seq

Overview:
Parametrised, registered N-to-2^N one-hot decoder, the next generation of the team's combinational 3x8 decoders. It adds three sequenced modes on top of direct decode: auto-scan up, auto-scan down, and a timed one-shot strobe. Typical uses are display digit/row strobing and peripheral select sequencing. It sits between control logic and one-hot select/strobe lines.

Parameters:
SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived localparam, not overridable)
DWELL_W, 8, width of dwell-count input; hold time = dwell+1 cycles

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
en  in  1  global enable; low forces y=0 next cycle and freezes scan/aborts pulse
mode  in  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 ONESHOT
sel  in  SEL_W  decode index (DIRECT), pulse index (ONESHOT); ignored in scan
dwell  in  DWELL_W  cycles-1 each index is held (scan, one-shot)
start  in  1  one-shot trigger, level-sampled each cycle
y  out  OUT_W  registered one-hot output (all-zero when inactive)
idx  out  SEL_W  index currently driven on y (registered)
busy  out  1  high while one-shot strobe active
wrap  out  1  one-cycle pulse on scan wrap-around

Behaviour:
- Reset: y=0, idx=0, busy=0, wrap=0, dwell counter=0, state IDLE. Reset wins over all inputs.
- States: IDLE, DIRECT, SCAN, PULSE. From IDLE/DIRECT/SCAN, the next state follows mode: 00->DIRECT, 01/10->SCAN, 11->IDLE (waiting for start). en=0 holds idx and the counter but forces y=0.
- Invariant: y is either all-zero or onehot(idx), never multi-hot.
- DIRECT: latency 1. y <= en ? onehot(sel) : 0; idx <= sel. dwell is ignored.
- SCAN: the counter loads dwell at each index entry and decrements while en=1.
  - When the counter hits 0, idx steps ±1 modulo OUT_W and the counter reloads the current dwell.
  - dwell=0 steps every cycle. dwell is sampled only at reload.
  - wrap=1 in the same cycle that idx becomes 0 (UP, from OUT_W-1) or becomes OUT_W-1 (DOWN, from 0).
  - Entering SCAN from another state keeps idx and clears the counter to dwell.
  - Switching UP<->DOWN mid-scan takes effect at the next step, without a reload.
- ONESHOT: in IDLE with mode=11, en=1 and start=1, the cycle after: idx<=sel, y<=onehot(sel), busy=1, counter<=dwell.
  - The strobe stays high for exactly dwell+1 cycles. Then y=0, busy=0, back to IDLE.
  - start while busy is ignored; no queuing.
  - start held high re-triggers only after one idle cycle (busy=0 for at least 1 cycle).
  - en=0 or mode!=11 during PULSE aborts: the next cycle gives y=0, busy=0, and the state follows mode.
- Mode change: takes effect on the next clock. There is no glitch cycle with two bits set.
- rst asserted mid-scan or mid-pulse returns everything to reset values on the next edge.
- Widths: the counter is DWELL_W bits unsigned. idx arithmetic wraps naturally at SEL_W bits.

Decomposition:
- Package decoder_pkg holds:
  - mode_t enum (MODE_DIRECT, MODE_SCAN_UP, MODE_SCAN_DOWN, MODE_ONESHOT)
  - state_t enum (IDLE, DIRECT, SCAN, PULSE)
  - function onehot(idx) returning OUT_W bits
- One sub-module, dwell_timer: loadable down-counter with load, dec, value, and a zero flag. It is reused by both SCAN and PULSE.

Test Plan:
- Direct decode (SEL_W=3, mode=00, en=1): sweep sel 0..7 -> y = 0x01,0x02,...,0x80, each one cycle after sel; en=0 -> y=0x00 next cycle.
- Scan up, dwell=2: y = 0x01 for 3 cycles, then 0x02... up to 0x80, then 0x01 with wrap=1 for exactly that one cycle; 24 cycles per full sweep.
- Scan down, dwell=0, after reset: idx 0 -> 7 with wrap=1, then 6,5,...; y changes every cycle; en low for 4 cycles freezes idx and gives y=0, then resume continues from the frozen idx.
- One-shot, sel=5, dwell=3, start pulse: y=0x20 and busy=1 for exactly 4 cycles, then 0; a second start during busy is ignored.
- Abort/reset: one-shot dwell=10, drop en at cycle 3 -> y=0, busy=0 next cycle. Separately, assert rst mid-scan -> y=0, idx=0, wrap=0 next edge.
- Random mode/en/start/dwell stress with an assertion: y is zero or onehot(idx), and never multi-hot.
